match_event_monitor: RTL

- Downstream consumer of the 1001 Mealy sequence detector's `out` pulse. Sits directly after the detector.
- Qualifies each detector output bit with a bit-valid strobe, counts detections, and timestamps the last detection in bit-index units.
- Raises a sticky burst alarm when too many detections land inside a sliding window of recent bits.
- Its outputs feed status registers and interrupt logic.

---
 rtl/match_event_monitor.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/match_event_monitor.sv
// -----------------------------------------------------------------------------
// match_event_monitor
//   Post-processor for a 1001 Mealy sequence detector output. Each detector bit
//   is qualified by a bit-valid strobe. The block counts qualified matches,
//   timestamps the most recent one in bit-index units and raises a sticky burst
//   alarm when THRESH or more matches fall inside the last WIN qualified bits.
//
// Ports
//   clk         : rising-edge clock
//   rst         : synchronous active-low reset (highest priority)
//   en          : bit-valid qualifier; nothing advances while low
//   match_in    : detector output for the current bit
//   clr         : synchronous clear of counters, window, timestamp and alarm
//   match_pulse : registered single-cycle copy of a qualified match
//   match_cnt   : saturating count of qualified matches
//   last_ts     : bit index of the most recent qualified match
//   ts          : current bit index (qualified bits since reset/clr, wraps)
//   burst_alarm : sticky alarm, high while the FSM is in ALARM
//   state       : FSM state (00 IDLE, 01 ACTIVE, 10 ALARM)
// -----------------------------------------------------------------------------
module match_event_monitor #(
    parameter int CNT_W  = 8,
    parameter int TS_W   = 16,
    parameter int WIN    = 16,
    parameter int THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             match_in,
    input  logic             clr,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic [TS_W-1:0]  last_ts,
    output logic [TS_W-1:0]  ts,
    output logic             burst_alarm,
    output logic [1:0]       state
);

    localparam int WC_W = $clog2(WIN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        ALARM  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TS_W-1:0]  last_ts_q, last_ts_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic             alarm_q, alarm_d;
    logic [WIN-1:0]   win_q, win_d;
    logic [WC_W-1:0]  win_cnt_q, win_cnt_d;

    // Next-state logic for counters, window and FSM; clr beats en.
    always_comb begin
        state_d   = state_q;
        pulse_d   = 1'b0;
        cnt_d     = cnt_q;
        last_ts_d = last_ts_q;
        ts_d      = ts_q;
        win_d     = win_q;
        win_cnt_d = win_cnt_q;

        if (clr) begin
            state_d   = IDLE;
            cnt_d     = '0;
            last_ts_d = '0;
            ts_d      = '0;
            win_d     = '0;
            win_cnt_d = '0;
        end else if (en) begin
            ts_d  = ts_q + TS_W'(1);
            // Bit WIN-1 was sampled WIN qualified samples ago and leaves now.
            win_d = {win_q[WIN-2:0], match_in};
            // Intermediate may wrap when WIN+1 is a power of two; the
            // modular result still lands in 0..WIN.
            win_cnt_d = win_cnt_q + WC_W'(match_in) - WC_W'(win_q[WIN-1]);

            if (match_in) begin
                pulse_d   = 1'b1;
                last_ts_d = ts_q;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                pulse_d = 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // Window is empty in IDLE, so only THRESH=1 can jump to ALARM.
                    if (match_in) begin
                        if (win_cnt_d >= WC_W'(THRESH)) begin
                            state_d = ALARM;
                        end else begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACTIVE: begin
                    if (win_cnt_d >= WC_W'(THRESH)) begin
                        state_d = ALARM;
                    end else begin
                        state_d = ACTIVE;
                    end
                end
                ALARM:   state_d = ALARM;
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end

        alarm_d = (state_d == ALARM);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
            last_ts_q <= '0;
            ts_q      <= '0;
            alarm_q   <= 1'b0;
            win_q     <= '0;
            win_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
            last_ts_q <= last_ts_d;
            ts_q      <= ts_d;
            alarm_q   <= alarm_d;
            win_q     <= win_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    assign match_pulse = pulse_q;
    assign match_cnt   = cnt_q;
    assign last_ts     = last_ts_q;
    assign ts          = ts_q;
    assign burst_alarm = alarm_q;
    assign state       = state_q;

endmodule
